// File: rtl/vga_mem_arbiter_pkg.sv
// Shared types for the VGA memory arbiter: bus-width defaults, aux FSM states, return-tag encoding.
package vga_mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } aux_state_t;

    typedef enum logic {
        SRC_PIX = 1'b0,
        SRC_AUX = 1'b1
    } tag_src_t;

    typedef struct packed {
        logic     vld;
        tag_src_t src;
        logic     we;
    } tag_t;

endpackage

// File: rtl/vga_mem_tag_pipe.sv
// Two-stage shift of access tags so returning memory data can be routed to its requester.
// Latency 2 cycles, no backpressure: a tag advances every clock.
module vga_mem_tag_pipe
    import vga_mem_arbiter_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  tag_t i_tag,
    output tag_t o_tag
);

    tag_t r_s1;
    tag_t r_s2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_tag;
            r_s2 <= r_s1;
        end
    end

    assign o_tag = r_s2;

endmodule

// File: rtl/vga_mem_arbiter.sv
// Fixed-priority arbiter sharing a single-port memory between pixel fetch and an aux port.
// Pixel reads return exactly 2 cycles after grant; aux waits for a pixel-free cycle and flags starvation.
module vga_mem_arbiter
    import vga_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pix_req,
    input  logic [ADDR_W-1:0] i_pix_addr,
    output logic              o_pix_rvalid,
    output logic [DATA_W-1:0] o_pix_rdata,
    input  logic              i_aux_req,
    input  logic              i_aux_we,
    input  logic [ADDR_W-1:0] i_aux_addr,
    input  logic [DATA_W-1:0] i_aux_wdata,
    output logic              o_aux_ack,
    output logic              o_aux_rvalid,
    output logic [DATA_W-1:0] o_aux_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_aux_starve
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    aux_state_t        r_state;
    aux_state_t        w_state_nxt;
    logic              w_aux_grant;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_pix_rvalid;
    logic [DATA_W-1:0] r_pix_rdata;
    logic              r_aux_rvalid;
    logic [DATA_W-1:0] r_aux_rdata;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_starve;
    tag_t              w_tag_in;
    tag_t              w_tag_out;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_aux_req && !i_pix_req) w_state_nxt = ST_ACK;
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A request still held in ACK is deliberately invisible, so one request yields one access.
    always_comb begin
        w_aux_grant = (r_state == ST_IDLE) && i_aux_req && !i_pix_req;
        o_aux_ack   = (r_state == ST_ACK);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_en <= i_pix_req || w_aux_grant;
            r_mem_we <= w_aux_grant && i_aux_we;
            if (i_pix_req) begin
                r_mem_addr <= i_pix_addr;
            end else if (w_aux_grant) begin
                r_mem_addr  <= i_aux_addr;
                r_mem_wdata <= i_aux_wdata;
            end
        end
    end

    always_comb begin
        w_tag_in.vld = i_pix_req || w_aux_grant;
        w_tag_in.src = i_pix_req ? SRC_PIX : SRC_AUX;
        w_tag_in.we  = w_aux_grant && i_aux_we;
    end

    vga_mem_tag_pipe u_tag_pipe (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pix_rvalid <= 1'b0;
            r_pix_rdata  <= '0;
            r_aux_rvalid <= 1'b0;
            r_aux_rdata  <= '0;
        end else begin
            r_pix_rvalid <= w_tag_out.vld && (w_tag_out.src == SRC_PIX);
            r_aux_rvalid <= w_tag_out.vld && (w_tag_out.src == SRC_AUX) && !w_tag_out.we;
            if (w_tag_out.vld && (w_tag_out.src == SRC_PIX))
                r_pix_rdata <= i_mem_rdata;
            if (w_tag_out.vld && (w_tag_out.src == SRC_AUX) && !w_tag_out.we)
                r_aux_rdata <= i_mem_rdata;
        end
    end

    // Starvation only raises a flag; the pixel path keeps absolute priority.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wait_cnt <= '0;
            r_starve   <= 1'b0;
        end else begin
            if (!i_aux_req || w_aux_grant)
                r_wait_cnt <= '0;
            else if ((r_state == ST_IDLE) && (r_wait_cnt != MAX_CNT))
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            if (r_wait_cnt == MAX_CNT)
                r_starve <= 1'b1;
        end
    end

    assign o_mem_en     = r_mem_en;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_pix_rvalid = r_pix_rvalid;
    assign o_pix_rdata  = r_pix_rdata;
    assign o_aux_rvalid = r_aux_rvalid;
    assign o_aux_rdata  = r_aux_rdata;
    assign o_aux_starve = r_starve;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Randomised and directed bench for vga_mem_arbiter against a transaction-level reference model.
module tb_vga_mem_arbiter;

    localparam int AW = 11;
    localparam int DW = 8;
    localparam int MAXW = 20;

    logic          clk;
    logic          rst;
    logic          pix_req;
    logic [AW-1:0] pix_addr;
    logic          pix_rvalid;
    logic [DW-1:0] pix_rdata;
    logic          aux_req;
    logic          aux_we;
    logic [AW-1:0] aux_addr;
    logic [DW-1:0] aux_wdata;
    logic          aux_ack;
    logic          aux_rvalid;
    logic [DW-1:0] aux_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          aux_starve;

    vga_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAXW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_pix_req    (pix_req),
        .i_pix_addr   (pix_addr),
        .o_pix_rvalid (pix_rvalid),
        .o_pix_rdata  (pix_rdata),
        .i_aux_req    (aux_req),
        .i_aux_we     (aux_we),
        .i_aux_addr   (aux_addr),
        .i_aux_wdata  (aux_wdata),
        .o_aux_ack    (aux_ack),
        .o_aux_rvalid (aux_rvalid),
        .o_aux_rdata  (aux_rdata),
        .o_mem_en     (mem_en),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata),
        .o_aux_starve (aux_starve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External single-port memory with one-cycle registered read.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: a list of outstanding returns with due cycle, plus shadow memory.
    typedef struct {
        int            due;
        bit            is_pix;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          ret_q[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            cyc = 0;
    int            blocked = 0;
    bit            was_rst = 1'b0;
    bit            e_mem_en, e_mem_we, e_ack, e_starve, e_pix_v, e_aux_v;
    logic [AW-1:0] e_mem_addr;
    logic [DW-1:0] e_mem_wdata, e_pix_d, e_aux_d;

    task automatic model_step();
        bit gp, ga;
        ret_t r;
        cyc++;
        was_rst = rst;
        if (rst) begin
            e_mem_en = 0; e_mem_we = 0; e_mem_addr = '0; e_mem_wdata = '0;
            e_pix_v = 0; e_pix_d = '0; e_aux_v = 0; e_aux_d = '0;
            e_ack = 0; e_starve = 0; blocked = 0;
            ret_q.delete();
            return;
        end
        gp = pix_req;
        ga = !pix_req && aux_req && !e_ack;
        if (blocked == MAXW) e_starve = 1;
        if (!aux_req || ga) blocked = 0;
        else if (!e_ack && blocked < MAXW) blocked++;
        e_mem_en = gp || ga;
        e_mem_we = ga && aux_we;
        if (gp) begin
            e_mem_addr = pix_addr;
            r.due = cyc + 2; r.is_pix = 1; r.data = ref_mem[pix_addr];
            ret_q.push_back(r);
        end else if (ga) begin
            e_mem_addr  = aux_addr;
            e_mem_wdata = aux_wdata;
            if (aux_we) ref_mem[aux_addr] = aux_wdata;
            else begin
                r.due = cyc + 2; r.is_pix = 0; r.data = ref_mem[aux_addr];
                ret_q.push_back(r);
            end
        end
        e_ack = ga;
        e_pix_v = 0;
        e_aux_v = 0;
        while (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            r = ret_q.pop_front();
            if (r.is_pix) begin e_pix_v = 1; e_pix_d = r.data; end
            else          begin e_aux_v = 1; e_aux_d = r.data; end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("mem_en", 32'(mem_en), 32'(e_mem_en));
        chk("mem_we", 32'(mem_we), 32'(e_mem_we));
        if (e_mem_en || was_rst) chk("mem_addr", 32'(mem_addr), 32'(e_mem_addr));
        if (e_mem_we || was_rst) chk("mem_wdata", 32'(mem_wdata), 32'(e_mem_wdata));
        chk("pix_rvalid", 32'(pix_rvalid), 32'(e_pix_v));
        chk("pix_rdata", 32'(pix_rdata), 32'(e_pix_d));
        chk("aux_rvalid", 32'(aux_rvalid), 32'(e_aux_v));
        chk("aux_rdata", 32'(aux_rdata), 32'(e_aux_d));
        chk("aux_ack", 32'(aux_ack), 32'(e_ack));
        chk("aux_starve", 32'(aux_starve), 32'(e_starve));
        chk("rvalid_excl", 32'(pix_rvalid && aux_rvalid), 32'(0));
    endtask

    task automatic idle_inputs();
        pix_req = 0; pix_addr = '0; aux_req = 0; aux_we = 0; aux_addr = '0; aux_wdata = '0;
    endtask

    task automatic do_reset(input int n);
        rst = 1;
        for (int i = 0; i < n; i++) cycle();
        rst = 0;
    endtask

    // Hold an aux request until the ack is seen, bounded.
    task automatic aux_txn(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int k;
        aux_req = 1; aux_we = we; aux_addr = a; aux_wdata = d;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!aux_ack && k < 50);
        chk("aux_txn_ack_seen", 32'(aux_ack), 32'(1));
        aux_req = 0;
    endtask

    int pix_seen, acks, mem_acc;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = DW'(i);
            ref_mem[i] = DW'(i);
        end
        mem_rdata = '0;
        idle_inputs();
        rst = 1;
        do_reset(3);

        // Burst of back-to-back pixel reads
        pix_seen = 0;
        for (int i = 0; i < 16; i++) begin
            pix_req = 1; pix_addr = AW'(i);
            cycle();
            pix_seen += pix_rvalid;
        end
        pix_req = 0;
        for (int i = 0; i < 4; i++) begin cycle(); pix_seen += pix_rvalid; end
        chk("burst_pix_count", 32'(pix_seen), 32'(16));

        // Aux write then read-back
        aux_txn(1, 11'h123, 8'hA5);
        aux_txn(0, 11'h123, 8'h00);
        cycle();
        cycle();
        chk("aux_readback", 32'(aux_rdata), 32'hA5);

        // Contention: pixel wins, aux waits
        aux_req = 1; aux_we = 0; aux_addr = 11'h040; aux_wdata = '0;
        for (int i = 0; i < 5; i++) begin
            pix_req = 1; pix_addr = AW'(11'h200 + i);
            cycle();
        end
        pix_req = 0;
        cycle();
        chk("contend_ack_first_free", 32'(aux_ack), 32'(1));
        aux_req = 0;
        for (int i = 0; i < 4; i++) cycle();

        // Request held through the ack cycle is not served twice
        acks = 0; mem_acc = 0;
        aux_req = 1; aux_we = 0; aux_addr = 11'h055;
        for (int i = 0; i < 2; i++) begin cycle(); acks += aux_ack; mem_acc += mem_en; end
        aux_req = 0;
        for (int i = 0; i < 3; i++) begin cycle(); acks += aux_ack; mem_acc += mem_en; end
        chk("held_req_acks", 32'(acks), 32'(1));
        chk("held_req_mem_acc", 32'(mem_acc), 32'(1));

        // Starvation under continuous pixel traffic
        aux_req = 1; aux_we = 1; aux_addr = 11'h321; aux_wdata = 8'h3C;
        for (int i = 0; i < MAXW + 5; i++) begin
            pix_req = 1; pix_addr = AW'($urandom_range(0, (1 << AW) - 1));
            cycle();
        end
        chk("starve_set", 32'(aux_starve), 32'(1));
        pix_req = 0;
        cycle();
        aux_req = 0;
        for (int i = 0; i < 4; i++) cycle();
        chk("starve_sticky", 32'(aux_starve), 32'(1));
        do_reset(1);
        chk("starve_cleared", 32'(aux_starve), 32'(0));

        // Reset right after a pixel grant discards its return
        pix_req = 1; pix_addr = 11'h00A;
        cycle();
        pix_req = 0;
        do_reset(1);
        chk("rst_all_zero", 32'({mem_en, mem_we, mem_addr, mem_wdata, pix_rvalid, pix_rdata,
                                  aux_ack, aux_rvalid, aux_rdata, aux_starve}), 32'(0));
        pix_seen = 0;
        for (int i = 0; i < 4; i++) begin cycle(); pix_seen += pix_rvalid; end
        chk("rst_discard", 32'(pix_seen), 32'(0));

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            pix_req   = ($urandom_range(0, 99) < 55);
            pix_addr  = AW'($urandom);
            if (aux_ack || !aux_req) begin
                aux_req   = ($urandom_range(0, 99) < 40);
                aux_we    = $urandom_range(0, 1) == 1;
                aux_addr  = AW'($urandom_range(0, 31));
                aux_wdata = DW'($urandom);
            end
            cycle();
        end
        rst = 0;
        idle_inputs();
        for (int i = 0; i < 4; i++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
